// File: rtl/crc16_pkg.sv
// crc16_pkg: shared CRC-16 constants, frame widths and framer state encoding
package crc16_pkg;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;
  localparam int DATA_W = 32;
  localparam int CRC_W = 16;
  localparam int FRAME_W = 48;
  typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;
endpackage

// File: rtl/crc16_lfsr_step.sv
// crc16_lfsr_step: one MSB-first bit step of the CRC-16 LFSR
module crc16_lfsr_step
  import crc16_pkg::*;
(
  input  logic [CRC_W-1:0] crc,
  input  logic             din,
  output logic [CRC_W-1:0] crc_next
);
  assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ ((din ^ crc[CRC_W-1]) ? CRC16_POLY : '0);
endmodule

// File: rtl/crc16_tx_framer.sv
// crc16_tx_framer: serialises data word plus CRC MSB-first and rechecks the CRC
module crc16_tx_framer
  import crc16_pkg::*;
#(
  parameter int CHECK_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CRC_W-1:0]  in_crc,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_bit,
  output logic              tx_sof,
  output logic              tx_eof,
  output logic              done,
  output logic              crc_ok
);
  state_t state, state_n;
  logic [FRAME_W-1:0] shift;
  logic [5:0] cnt;
  logic [CRC_W-1:0] lfsr, lfsr_n, cap;
  logic ok, xfer;
  assign in_ready = state == IDLE;
  assign tx_valid = state == DATA || state == CRC;
  assign xfer = tx_valid && tx_ready;
  assign tx_bit = shift[FRAME_W-1];
  assign tx_sof = tx_valid && cnt == 6'd47;
  assign tx_eof = tx_valid && cnt == 6'd0;
  assign done = state == DONE;
  assign crc_ok = ok;
  crc16_lfsr_step u_step (.crc(lfsr), .din(tx_bit), .crc_next(lfsr_n));
  // next-state decode: data bits until counter 16, CRC bits until 0, one DONE cycle
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? DATA : IDLE)
            : state == DATA ? (xfer && cnt == 6'd16 ? CRC : DATA)
            : state == CRC  ? (xfer && cnt == 6'd0 ? DONE : CRC)
            : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // shift register, bit counter, LFSR recompute and latched compare result
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      cnt <= '0;
      lfsr <= CRC16_INIT;
      cap <= '0;
      ok <= 1'b0;
    end else if (in_ready && in_valid) begin
      shift <= {in_data, in_crc};
      cap <= in_crc;
      lfsr <= CRC16_INIT;
      cnt <= 6'd47;
    end else if (xfer) begin
      shift <= {shift[FRAME_W-2:0], 1'b0};
      cnt <= cnt == 6'd0 ? cnt : cnt - 6'd1;
      if (state == DATA) lfsr <= lfsr_n;
      if (cnt == 6'd0) ok <= (lfsr == cap) || (CHECK_EN == 0);
    end
  end
endmodule

// File: doc/crc16_tx_framer.md
# crc16_tx_framer

Downstream stage of the serial CRC-16 generator. It accepts a 32-bit data word together with the CRC-16 computed for it, and serialises a 48-bit frame MSB-first on a 1-bit valid/ready stream: 32 data bits, then 16 CRC bits. While shifting the data bits it recomputes the CRC with its own bit-serial LFSR. At frame end it reports whether the supplied CRC matched.

## Interface
Parameters:
- `CHECK_EN`, default 1: 1 enables the internal CRC recompute and compare; 0 forces `crc_ok`=1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  word + CRC offered.
- `in_ready`  out  1  framer can accept a word.
- `in_data`  in  32  data word, bit 31 sent first.
- `in_crc`  in  16  CRC-16 of `in_data` from the CRC stage.
- `tx_valid`  out  1  `tx_bit` is valid.
- `tx_ready`  in  1  sink accepts `tx_bit`.
- `tx_bit`  out  1  serial frame bit.
- `tx_sof`  out  1  qualifies frame bit 47, the first data bit.
- `tx_eof`  out  1  qualifies frame bit 0, the last CRC bit.
- `done`  out  1  one-cycle pulse after the last bit is transferred.
- `crc_ok`  out  1  compare result; valid while `done`=1, held until the next `done`.

## Operation
- CRC definition:
  - polynomial 0x1021 (x^16+x^12+x^5+1), init 0x0000;
  - MSB-first, no reflection, no final XOR;
  - identical to the upstream generator.
- LFSR step: fb = bit ^ crc[15]; crc = {crc[14:0],0} ^ (fb ? 0x1021 : 0).
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`:
    - load shift register {in_data,in_crc} and the captured CRC;
    - clear the LFSR to 0x0000 and the bit counter to 47;
    - go to DATA.
  - DATA: `tx_bit`=shift[47], `tx_valid`=1. On each transfer (`tx_valid`&&`tx_ready`):
    - step the LFSR with `tx_bit`;
    - shift left by 1 and decrement the counter;
    - after the transfer at counter 16, go to CRC.
  - CRC: same shifting; the LFSR does not step. After the transfer at counter 0, go to DONE.
  - DONE: for one cycle, `done`=1 and `crc_ok`=(LFSR==captured CRC)|!CHECK_EN. Then go to IDLE.
- Stall: with `tx_ready`=0, `tx_bit`, `tx_sof`, `tx_eof`, counter and LFSR hold unchanged. `tx_valid` never drops mid-frame.
- `in_ready` is high only in IDLE. A word offered in DONE waits one cycle.
- `tx_sof`=`tx_valid`&&(counter==47); `tx_eof`=`tx_valid`&&(counter==0).
- Counter is 6 bits and never wraps: the 0 to IDLE path goes through DONE.
- `in_data`/`in_crc` are sampled only on the accept cycle. Later changes are ignored.

## Timing
- Reset values: state IDLE, `in_ready`=1, `tx_valid`=0, `tx_bit`=0, `tx_sof`=0, `tx_eof`=0, `done`=0, `crc_ok`=0, LFSR 0x0000, counter 0.
- `rst` asserted mid-frame: the next cycle is in IDLE with reset values. The frame is dropped and no `done` pulse occurs.
- Accept at edge N: first bit (`tx_sof`) is valid in cycle N+1.
- With `tx_ready` held 1: bits occupy N+1..N+48, `done` in N+49, `in_ready` again in N+50. Minimum frame period is 50 cycles.
- All outputs are registered or decoded from state/counter only. There is no combinational path from `in_*` to `tx_*`.
- `in_ready` depends on state only, never on `in_valid`.

## Structure
- Package `crc16_pkg`:
  - `CRC16_POLY`=16'h1021, `CRC16_INIT`=16'h0000;
  - `DATA_W`=32, `CRC_W`=16, `FRAME_W`=48;
  - the state enum {IDLE, DATA, CRC, DONE}.
- Sub-module `crc16_lfsr_step`: purely combinational. Inputs (crc[15:0], bit), output next crc. It will also be reused by the upstream generator rewrite.

## Test plan
- `in_data`=0x00000001, `in_crc`=0x1021, `tx_ready`=1:
  - bit stream is 31×0, 1, then 0001_0000_0010_0001;
  - `tx_sof` on the first bit, `tx_eof` on the last;
  - `done`=1 with `crc_ok`=1 at accept+49.
- `in_data`=0x00000002, `in_crc`=0x2042 gives `crc_ok`=1. Same data with `in_crc`=0x2043 gives `crc_ok`=0, and bit 0 of the stream is 1.
- Random `tx_ready` (50% duty) on 0xDEADBEEF with its generator CRC:
  - stream equals the no-stall stream;
  - `tx_bit` is stable during stalls; `crc_ok`=1.
- `rst` pulsed at bit 20 of a frame: next cycle `tx_valid`=0, `in_ready`=1, no `done`. The next frame (0x00000001/0x1021) completes with `crc_ok`=1.
- `in_valid` held high with 3 back-to-back words:
  - accepts are spaced exactly 50 cycles apart;
  - `in_ready`=0 from accept+1 through accept+49.
- `CHECK_EN`=0 with a wrong `in_crc`: stream is unchanged and `crc_ok`=1.
